// File: rtl/gat_run_ctrl.sv
// Run sequencer for the GAT core: gathers load-done flags, fires the start pulse,
// counts subgraph completions, then drains the new-feature BRAM onto a valid/ready stream.
module gat_run_ctrl #(
  parameter int TOP_WIDTH          = 32,
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int BRAM_RD_LAT        = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          h_data_bram_load_done,
  input  logic                          h_node_info_bram_load_done,
  input  logic                          wgt_bram_load_done,
  input  logic                          soft_clear,
  input  logic                          subgraph_done,
  output logic                          gat_start,
  output logic                          gat_ready,
  output logic [TOP_WIDTH-1:0]          ctrl_debug,
  output logic                          feat_bram_enb,
  output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  feat_out_data,
  output logic                          feat_out_valid,
  input  logic                          feat_out_ready,
  output logic                          feat_out_last
);

  localparam int FIFO_DEPTH = BRAM_RD_LAT + 2;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int FCW        = $clog2(FIFO_DEPTH + 1);
  localparam int OW         = FCW + 1;
  localparam int CW         = NEW_FEATURE_ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                        state_q, state_d;
  logic [2:0]                    ld_q, ld_d, ld_now;
  logic [15:0]                   sg_cnt_q, sg_cnt_d;
  logic [CW-1:0]                 rd_addr_q, rd_addr_d;
  logic [CW-1:0]                 out_cnt_q, out_cnt_d;
  logic [BRAM_RD_LAT-1:0]        pipe_q, pipe_d;
  logic [FCW-1:0]                fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NEW_FEATURE_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [OW-1:0]                 occ;
  logic                          issue, push, pop, valid, last_word;
  logic [31:0]                   dbg_word;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reads in flight plus buffered words may never exceed the FIFO, so a stalled
  // consumer can never cause returning data to be dropped.
  always_comb begin
    occ = OW'(fifo_cnt_q);
    for (int i = 0; i < BRAM_RD_LAT; i++) begin
      occ = occ + OW'(pipe_q[i]);
    end
  end

  assign ld_now    = ld_q | {h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done};
  assign issue     = (state_q == S_DRAIN) && (rd_addr_q < CW'(NEW_FEATURE_DEPTH)) &&
                     (occ < OW'(FIFO_DEPTH));
  assign push      = (state_q == S_DRAIN) && pipe_q[BRAM_RD_LAT-1];
  assign valid     = (state_q == S_DRAIN) && (fifo_cnt_q != '0);
  assign pop       = valid && feat_out_ready;
  assign last_word = (out_cnt_q == CW'(NEW_FEATURE_DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    ld_d       = ld_now;
    sg_cnt_d   = sg_cnt_q;
    rd_addr_d  = rd_addr_q + CW'(issue);
    out_cnt_d  = out_cnt_q + CW'(pop);
    fifo_cnt_d = fifo_cnt_q + FCW'(push) - FCW'(pop);
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    pipe_d[0]  = issue;
    for (int i = 1; i < BRAM_RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    unique case (state_q)
      S_IDLE: begin
        if (ld_now == 3'b111) state_d = S_START;
      end
      S_START: begin
        sg_cnt_d   = '0;
        rd_addr_d  = '0;
        out_cnt_d  = '0;
        fifo_cnt_d = '0;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (subgraph_done) begin
          sg_cnt_d = sg_cnt_q + 16'd1;
          if (({1'b0, sg_cnt_q} + 17'd1) == 17'(NUM_SUBGRAPHS)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && last_word) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort/finish wins over every other event, including a same-cycle handshake.
    if (soft_clear) begin
      state_d    = S_IDLE;
      ld_d       = '0;
      sg_cnt_d   = '0;
      rd_addr_d  = '0;
      out_cnt_d  = '0;
      fifo_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pipe_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ld_q       <= '0;
      sg_cnt_q   <= '0;
      rd_addr_q  <= '0;
      out_cnt_q  <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pipe_q     <= '0;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      sg_cnt_q   <= sg_cnt_d;
      rd_addr_q  <= rd_addr_d;
      out_cnt_q  <= out_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pipe_q     <= pipe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= feat_bram_dout;
  end

  // Data storage is not reset, so the stream data is gated to read zero when idle.
  assign dbg_word        = {state_q, ld_q, 10'd0, sg_cnt_q};
  assign ctrl_debug      = TOP_WIDTH'(dbg_word);
  assign gat_start       = (state_q == S_START);
  assign gat_ready       = (state_q == S_DONE);
  assign feat_bram_enb   = issue;
  assign feat_bram_addrb = rd_addr_q[NEW_FEATURE_ADDR_W-1:0];
  assign feat_out_valid  = valid;
  assign feat_out_data   = valid ? mem_q[rd_ptr_q] : '0;
  assign feat_out_last   = valid && last_word;

endmodule

// File: tb/tb_gat_run_ctrl.sv
// Directed/randomized bench for gat_run_ctrl with a small BRAM model and a stream scoreboard.
module tb_gat_run_ctrl;

  localparam int NSG   = 4;
  localparam int NFO   = 2;
  localparam int DEPTH = NSG * NFO;
  localparam int AW    = $clog2(DEPTH);
  localparam int LAT   = 2;
  localparam int FDEP  = LAT + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          h_ld, n_ld, w_ld;
  logic          soft_clear, subgraph_done;
  logic          gat_start, gat_ready;
  logic [31:0]   ctrl_debug;
  logic          feat_bram_enb;
  logic [AW-1:0] feat_bram_addrb;
  logic [31:0]   feat_bram_dout;
  logic [31:0]   feat_out_data;
  logic          feat_out_valid, feat_out_ready, feat_out_last;

  int tests  = 0;
  int failed = 0;
  int start_cnt = 0;

  gat_run_ctrl #(
    .TOP_WIDTH(32), .NEW_FEATURE_WIDTH(32), .NUM_SUBGRAPHS(NSG),
    .NUM_FEATURE_OUT(NFO), .BRAM_RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .h_data_bram_load_done(h_ld), .h_node_info_bram_load_done(n_ld),
    .wgt_bram_load_done(w_ld), .soft_clear(soft_clear), .subgraph_done(subgraph_done),
    .gat_start(gat_start), .gat_ready(gat_ready), .ctrl_debug(ctrl_debug),
    .feat_bram_enb(feat_bram_enb), .feat_bram_addrb(feat_bram_addrb),
    .feat_bram_dout(feat_bram_dout), .feat_out_data(feat_out_data),
    .feat_out_valid(feat_out_valid), .feat_out_ready(feat_out_ready),
    .feat_out_last(feat_out_last)
  );

  always #5 clk = ~clk;

  // BRAM model: read data for a request appears LAT cycles later; garbage otherwise.
  logic          s1_v = 1'b0, s2_v = 1'b0;
  logic [AW-1:0] s1_a = '0, s2_a = '0;
  logic [31:0]   junk = 32'hdead_beef;
  always @(posedge clk) begin
    s1_v <= feat_bram_enb;
    s1_a <= feat_bram_addrb;
    s2_v <= s1_v;
    s2_a <= s1_a;
    junk <= $urandom;
  end
  assign feat_bram_dout = s2_v ? 32'(s2_a) : junk;

  always @(negedge clk) if (gat_start === 1'b1) start_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st();  return 32'(ctrl_debug[31:29]); endfunction
  function automatic logic [31:0] ldf(); return 32'(ctrl_debug[28:26]); endfunction
  function automatic logic [31:0] sgc(); return 32'(ctrl_debug[15:0]);  endfunction

  task automatic pulse_ld(input int which);
    case (which)
      0: w_ld = 1'b1;
      1: h_ld = 1'b1;
      default: n_ld = 1'b1;
    endcase
    step();
    w_ld = 1'b0; h_ld = 1'b0; n_ld = 1'b0;
  endtask

  // wgt, h_data, node_info pulses five cycles apart; start must follow node_info by one cycle.
  task automatic run_loads();
    int s0;
    s0 = start_cnt;
    pulse_ld(0);
    chk("ld_after_wgt", ldf(), 32'd1);
    chk("no_start_wgt", 32'(gat_start), 32'd0);
    repeat (4) step();
    pulse_ld(1);
    chk("ld_after_h", ldf(), 32'd5);
    chk("no_start_h", 32'(gat_start), 32'd0);
    repeat (4) step();
    pulse_ld(2);
    chk("start_pulse", 32'(gat_start), 32'd1);
    chk("state_start", st(), 32'd1);
    chk("ld_all", ldf(), 32'd7);
    step();
    chk("start_one_cycle", 32'(gat_start), 32'd0);
    chk("state_run", st(), 32'd2);
    chk("start_count", 32'(start_cnt - s0), 32'd1);
  endtask

  task automatic run_subgraphs();
    for (int k = 1; k <= NSG; k++) begin
      repeat ($urandom_range(0, 3)) step();
      subgraph_done = 1'b1;
      step();
      subgraph_done = 1'b0;
      chk("sg_cnt", sgc(), 32'(k));
      chk("state_sg", st(), (k == NSG) ? 32'd3 : 32'd2);
    end
  endtask

  // Called in the first DRAIN cycle. Expected stream: words 0..DEPTH-1 in order.
  task automatic drain(input bit rnd, input int clear_at, output int got);
    int  issued = 0;
    int  acc = 0;
    bit  done = 0;
    bit  prev_stall = 0;
    logic [31:0] prev_d = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (acc == DEPTH) begin
        chk("gat_ready_after_last", 32'(gat_ready), 32'd1);
        chk("valid_after_done", 32'(feat_out_valid), 32'd0);
        if (!rnd) chk("drain_length", 32'(cyc), 32'(DEPTH + LAT + 1));
        done = 1;
      end else begin
        if (!rnd) feat_out_ready = 1'b1;
        else if (cyc >= 2 && cyc < 22) feat_out_ready = 1'b0;
        else feat_out_ready = 1'($urandom_range(0, 1));
        chk("gat_ready_early", 32'(gat_ready), 32'd0);
        if (feat_bram_enb) begin
          chk("rd_addr", 32'(feat_bram_addrb), 32'(issued));
          issued++;
          chk("outstanding_bound", 32'(issued - acc <= FDEP), 32'd1);
        end
        if (rnd && cyc == 21) begin
          chk("hold_outstanding", 32'(issued - acc), 32'(FDEP));
          chk("hold_valid", 32'(feat_out_valid), 32'd1);
        end
        if (prev_stall) begin
          chk("stall_valid_kept", 32'(feat_out_valid), 32'd1);
          chk("stall_data_kept", feat_out_data, prev_d);
        end
        if (feat_out_valid && feat_out_ready) begin
          chk("data", feat_out_data, 32'(acc));
          chk("last", 32'(feat_out_last), 32'(acc == DEPTH - 1));
          if (!rnd) chk("hs_cycle", 32'(cyc), 32'(LAT + 1 + acc));
          if (acc == clear_at) begin
            soft_clear = 1'b1;
            done = 1;
          end
          acc++;
        end
        prev_stall = feat_out_valid && !feat_out_ready;
        prev_d     = feat_out_data;
      end
      step();
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    got = acc;
  endtask

  task automatic do_clear();
    soft_clear = 1'b1;
    step();
    soft_clear = 1'b0;
    chk("clr_state", st(), 32'd0);
    chk("clr_ld", ldf(), 32'd0);
    chk("clr_ready", 32'(gat_ready), 32'd0);
    chk("clr_valid", 32'(feat_out_valid), 32'd0);
  endtask

  initial begin
    int got, k, s0;
    rst_n = 1'b0; h_ld = 1'b0; n_ld = 1'b0; w_ld = 1'b0;
    soft_clear = 1'b0; subgraph_done = 1'b0; feat_out_ready = 1'b0;

    step();
    chk("rst_start", 32'(gat_start), 32'd0);
    chk("rst_ready", 32'(gat_ready), 32'd0);
    chk("rst_debug", ctrl_debug, 32'd0);
    chk("rst_enb", 32'(feat_bram_enb), 32'd0);
    chk("rst_valid", 32'(feat_out_valid), 32'd0);
    chk("rst_data", feat_out_data, 32'd0);
    chk("rst_last", 32'(feat_out_last), 32'd0);
    step();
    rst_n = 1'b1;

    // Run 1: stray subgraph pulse in IDLE, sequential loads, full-rate drain.
    step();
    subgraph_done = 1'b1;
    step();
    subgraph_done = 1'b0;
    chk("stray_idle_sg", sgc(), 32'd0);
    chk("stray_idle_state", st(), 32'd0);
    run_loads();
    run_subgraphs();
    drain(1'b0, -1, got);
    chk("run1_words", 32'(got), 32'(DEPTH));
    chk("done_hold", 32'(gat_ready), 32'd1);
    chk("done_enb", 32'(feat_bram_enb), 32'd0);
    do_clear();

    // Run 2: all flags as levels in one cycle, stray pulse in START, random ready.
    h_ld = 1'b1; n_ld = 1'b1; w_ld = 1'b1;
    step();
    chk("same_cycle_start", 32'(gat_start), 32'd1);
    subgraph_done = 1'b1;
    step();
    subgraph_done = 1'b0;
    chk("level_single_start", 32'(gat_start), 32'd0);
    chk("stray_start_sg", sgc(), 32'd0);
    h_ld = 1'b0; n_ld = 1'b0; w_ld = 1'b0;
    run_subgraphs();
    drain(1'b1, -1, got);
    chk("run2_words", 32'(got), 32'(DEPTH));
    do_clear();

    // Run 3: soft_clear in the same cycle as a handshake, then a clean rerun.
    run_loads();
    run_subgraphs();
    k = $urandom_range(2, 5);
    drain(1'b0, k, got);
    soft_clear = 1'b0;
    chk("midclr_words", 32'(got), 32'(k + 1));
    chk("midclr_state", st(), 32'd0);
    chk("midclr_valid", 32'(feat_out_valid), 32'd0);
    chk("midclr_ld", ldf(), 32'd0);
    chk("midclr_enb", 32'(feat_bram_enb), 32'd0);
    repeat (4) step();
    chk("midclr_discard", 32'(feat_out_valid), 32'd0);
    chk("midclr_no_start", 32'(gat_start), 32'd0);
    run_loads();
    run_subgraphs();
    drain(1'b0, -1, got);
    chk("rerun_words", 32'(got), 32'(DEPTH));
    do_clear();

    // Run 4: asynchronous reset in the middle of RUN.
    run_loads();
    repeat (2) begin
      subgraph_done = 1'b1;
      step();
      subgraph_done = 1'b0;
    end
    chk("pre_reset_sg", sgc(), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_debug", ctrl_debug, 32'd0);
    chk("async_rst_start", 32'(gat_start), 32'd0);
    chk("async_rst_ready", 32'(gat_ready), 32'd0);
    chk("async_rst_valid", 32'(feat_out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    s0 = start_cnt;
    pulse_ld(0);
    repeat (4) step();
    pulse_ld(1);
    repeat (5) step();
    chk("post_rst_idle", st(), 32'd0);
    chk("post_rst_ld", ldf(), 32'd5);
    chk("post_rst_no_start", 32'(start_cnt - s0), 32'd0);
    pulse_ld(2);
    chk("post_rst_start", 32'(gat_start), 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gat_run_ctrl.md
# gat_run_ctrl

Run sequencer for the GAT accelerator core, placed between the register bank and `gat_top`. It latches the three BRAM load-done flags in any order and issues a one-cycle start pulse. It then counts per-subgraph completions, and afterwards streams the new-feature BRAM out through a valid/ready port with latency-tolerant buffering. `gat_ready` is raised only after the last feature word has been accepted downstream.

## Interface
- `TOP_WIDTH`, 32, width of the debug register word.
- `NEW_FEATURE_WIDTH`, 32, feature word width.
- `NUM_SUBGRAPHS`, 2708, subgraph completions expected per run; must be < 65536.
- `NUM_FEATURE_OUT`, 16, words per subgraph.
- `NEW_FEATURE_DEPTH`, `NUM_SUBGRAPHS*NUM_FEATURE_OUT`, feature words to drain.
- `NEW_FEATURE_ADDR_W`, `$clog2(NEW_FEATURE_DEPTH)`, word-address width.
- `BRAM_RD_LAT`, 2, feature BRAM read latency in cycles; ≥1.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `h_data_bram_load_done`  in  1  H data load complete.
- `h_node_info_bram_load_done`  in  1  node-info load complete.
- `wgt_bram_load_done`  in  1  weight load complete.
- `soft_clear`  in  1  pulse; aborts or finishes the run and returns to IDLE.
- `subgraph_done`  in  1  pulse from core, once per finished subgraph.
- `gat_start`  out  1  one-cycle core start pulse.
- `gat_ready`  out  1  run complete, all features drained.
- `ctrl_debug`  out  TOP_WIDTH  status word.
- `feat_bram_enb`  out  1  feature BRAM read enable.
- `feat_bram_addrb`  out  NEW_FEATURE_ADDR_W  feature BRAM word address.
- `feat_bram_dout`  in  NEW_FEATURE_WIDTH  feature BRAM read data.
- `feat_out_data`  out  NEW_FEATURE_WIDTH  stream data.
- `feat_out_valid`  out  1  stream valid.
- `feat_out_ready`  in  1  stream ready.
- `feat_out_last`  out  1  high with the final word.

## Operation
- **Load-done flags:** the three load-done inputs are treated as pulses or levels. Each sets a sticky flag `ld[2:0]` = {h_data, node_info, wgt}. Flags are cleared only by reset or `soft_clear`.
- **IDLE:** wait until `ld==3'b111` (including a flag set this same cycle), then go to START.
- **START:** `gat_start=1` for exactly one cycle; clear the subgraph counter `sg_cnt`; go to RUN.
- **RUN:** each `subgraph_done` increments `sg_cnt`. The pulse that makes `sg_cnt` reach `NUM_SUBGRAPHS` moves the FSM to DRAIN. `subgraph_done` is ignored in every other state.
- **DRAIN, read issue:** a read is issued (`feat_bram_enb=1`, `feat_bram_addrb=rd_addr`, then `rd_addr++`) when `rd_addr<NEW_FEATURE_DEPTH` and `inflight+fifo_cnt<FIFO_DEPTH`. `FIFO_DEPTH=BRAM_RD_LAT+2`.
- **DRAIN, returned data:** each returned word is written into the FIFO. `inflight` is tracked by a `BRAM_RD_LAT`-deep valid shift register.
- **DRAIN, output:** the FIFO head drives `feat_out_*`. A word pops on `valid&&ready`. `feat_out_last=1` when the head is word `NEW_FEATURE_DEPTH-1`.
- **DRAIN exit:** the pop of the last word moves the FSM to DONE.
- **DONE:** `gat_ready=1` is held until `soft_clear`.
- **`soft_clear`:** from any state, and with priority over all simultaneous events, go to IDLE next cycle. It clears `ld`, `sg_cnt`, `rd_addr`, the FIFO and the in-flight pipe. Read data still returning is discarded. `feat_out_valid` drops next cycle.
- **`ctrl_debug`:** [31:29] state encoding (IDLE=0, START=1, RUN=2, DRAIN=3, DONE=4); [28:26] `ld`; [25:16] zero; [15:0] `sg_cnt`.

## Timing
- **Reset values:** all outputs are 0; state is IDLE; all counters, flags and FIFO are empty. Reset takes effect immediately and asynchronously, mid-run included.
- **Start latency:** the last load flag is seen in cycle t; `gat_start` is high in cycle t+1.
- **Read pipeline:** for a read issued in cycle t, `feat_bram_dout` is sampled at the end of cycle t+BRAM_RD_LAT. That word can appear on `feat_out_data` from cycle t+BRAM_RD_LAT+1.
- **Drain start:** DRAIN is entered at edge e. The first read issues in the cycle after e; first `feat_out_valid` comes BRAM_RD_LAT+1 cycles later.
- **Throughput:** with `feat_out_ready` held high, one word per cycle is sustained. A full drain takes `NEW_FEATURE_DEPTH+BRAM_RD_LAT+1` cycles.
- **Stream rules:** data is held stable while `valid&&!ready`; `valid` is never withdrawn without a handshake, except on `soft_clear`.
- **No overflow:** with `ready` low indefinitely, at most `FIFO_DEPTH` words are issued, and no data is lost or duplicated.
- **`gat_ready` timing:** asserted the cycle after the last handshake.

## Test plan
- Load-done pulses arrive in order wgt, h_data, node_info, 5 cycles apart -> exactly one `gat_start`, 1 cycle after the node_info pulse; `ctrl_debug[28:26]` reads 3'b111.
- `NUM_SUBGRAPHS=4`, `NUM_FEATURE_OUT=2`; 4 `subgraph_done` pulses, plus a stray pulse in IDLE -> `sg_cnt` reaches 4 and the FSM is in DRAIN; the stray pulse is ignored.
- BRAM model returns `dout=addr`, `ready=1` -> outputs 0..7 on consecutive cycles, `last` only on 7; `gat_ready` goes high the cycle after.
- `ready` toggled randomly, with a 20-cycle low hold -> sequence 0..7 intact with no duplicates; `feat_bram_enb` stops after 4 outstanding words (`BRAM_RD_LAT=2`).
- `soft_clear` asserted mid-DRAIN, in the same cycle as a handshake -> IDLE next cycle, `valid=0`, `ld=0`; a rerun streams from address 0.
- `rst_n` low mid-RUN -> all outputs 0 immediately; after release, `gat_start` needs all three flags again.
